// File: rtl/bus_gen_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_gen_arbiter_pkg
// Shared definitions for the bus generator/arbiter:
//   ID_W         width of the destination ID held in the top byte of a packet
//   arb_state_t  per-bus transfer FSM states (ARB -> POP -> PUSH)
//   dest_kind_t  classification of a packet's destination field
//   dest_decode  maps a destination ID onto a dest_kind_t
// ---------------------------------------------------------------------------
package bus_gen_arbiter_pkg;

    localparam int ID_W = 8;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        DEST_UNICAST = 2'd0,
        DEST_BCAST   = 2'd1,
        DEST_DROP    = 2'd2
    } dest_kind_t;

    // A real device ID takes priority over the broadcast code, so a bus with
    // enough devices to reach the broadcast value still addresses that device.
    function automatic dest_kind_t dest_decode(
        input logic [ID_W-1:0] dest,
        input logic [ID_W-1:0] bcast,
        input int unsigned     drvrs
    );
        dest_kind_t kind;
        kind = DEST_DROP;
        if (32'(dest) < drvrs) begin
            kind = DEST_UNICAST;
        end else if (dest == bcast) begin
            kind = DEST_BCAST;
        end
        return kind;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
// One bus worth of round-robin arbitration and packet transfer. Each packet
// takes three cycles: ARB (pick a pending source), POP (strobe the source
// FIFO and capture its head word), PUSH (strobe the addressed destinations).
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous, active-low reset
//   pndng   per-device "source FIFO not empty"
//   d_pop   per-device head word of the source FIFO (first-word-fall-through)
//   pop     one-cycle pop strobe, one-hot on the granted source
//   push    one-cycle push strobes to destination FIFOs
//   d_push  last delivered packet, shared by all destinations
//
// Configuration macro
//   BCAST_INCL_SRC_EN  when defined, a broadcast also delivers to its source
// ---------------------------------------------------------------------------
module bus_rr_arbiter
    import bus_gen_arbiter_pkg::*;
#(
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   d_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [pckg_sz-1:0]              d_push
);

    localparam int IDX_W = (drvrs > 1) ? $clog2(drvrs) : 1;

`ifdef BCAST_INCL_SRC_EN
    localparam logic INCL_SRC = 1'b1;
`else
    localparam logic INCL_SRC = 1'b0;
`endif

    arb_state_t           state_reg,  state_next;
    logic [IDX_W-1:0]     grant_reg,  grant_next;
    logic [IDX_W-1:0]     ptr_reg,    ptr_next;
    logic [drvrs-1:0]     pop_reg,    pop_next;
    logic [drvrs-1:0]     push_reg,   push_next;
    logic [pckg_sz-1:0]   d_push_reg, d_push_next;

    logic                 found;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     idx;
    logic [pckg_sz-1:0]   head;
    logic [ID_W-1:0]      dest;
    dest_kind_t           kind;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= ARB;
            grant_reg  <= '0;
            ptr_reg    <= '0;
            pop_reg    <= '0;
            push_reg   <= '0;
            d_push_reg <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            ptr_reg    <= ptr_next;
            pop_reg    <= pop_next;
            push_reg   <= push_next;
            d_push_reg <= d_push_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        ptr_next    = ptr_reg;
        pop_next    = '0;
        push_next   = '0;
        d_push_next = d_push_reg;
        found       = 1'b0;
        cand        = '0;
        idx         = '0;
        head        = d_pop[grant_reg];
        dest        = head[pckg_sz-1 -: ID_W];
        kind        = dest_decode(dest, broadcast, drvrs);

        // First pending device at or above the pointer, wrapping around.
        for (int off = 0; off < drvrs; off++) begin
            idx = IDX_W'((int'(ptr_reg) + off) % drvrs);
            if (!found && pndng[idx]) begin
                found = 1'b1;
                cand  = idx;
            end
        end

        case (state_reg)
            ARB: begin
                if (found) begin
                    grant_next     = cand;
                    ptr_next       = (cand == IDX_W'(drvrs - 1)) ? '0 : cand + IDX_W'(1);
                    pop_next[cand] = 1'b1;
                    state_next     = POP;
                end
            end
            POP: begin
                // The head word is captured on the edge that ends the pop
                // cycle and presented during PUSH. A dropped packet leaves
                // the previously delivered word on the bus.
                for (int k = 0; k < drvrs; k++) begin
                    case (kind)
                        DEST_UNICAST: push_next[k] = (32'(dest) == 32'(k));
                        DEST_BCAST:   push_next[k] = INCL_SRC || (k != int'(grant_reg));
                        default:      push_next[k] = 1'b0;
                    endcase
                end
                if (kind != DEST_DROP) begin
                    d_push_next = head;
                end
                state_next = PUSH;
            end
            PUSH: begin
                state_next = ARB;
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    assign pop    = pop_reg;
    assign push   = push_reg;
    assign d_push = d_push_reg;

endmodule

// File: rtl/bus_gen_arbiter.sv
// ---------------------------------------------------------------------------
// bus_gen_arbiter
// Shared-bus generator and arbiter: 'bits' independent buses, each serving
// 'drvrs' devices. Every bus round-robins over its pending source FIFOs,
// pops the head packet and pushes it to the device(s) named in the packet's
// top byte (a device ID, the broadcast code, or anything else = drop).
//
// Ports
//   clk     rising-edge clock
//   reset   synchronous, active-low reset
//   pndng   [bits][drvrs]           source FIFO non-empty
//   D_pop   [bits][drvrs][pckg_sz]  source FIFO head word
//   pop     [bits][drvrs]           pop strobes to source FIFOs
//   push    [bits][drvrs]           push strobes to destination FIFOs
//   D_push  [bits][drvrs][pckg_sz]  delivered packet, same on every device
//
// Configuration macro
//   BCAST_INCL_SRC_EN  when defined, a broadcast also delivers to its source
// ---------------------------------------------------------------------------
module bus_gen_arbiter
    import bus_gen_arbiter_pkg::*;
#(
    parameter int         bits      = 1,
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [bits-1:0][drvrs-1:0]              pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
    output logic [bits-1:0][drvrs-1:0]              pop,
    output logic [bits-1:0][drvrs-1:0]              push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

    logic [bits-1:0][pckg_sz-1:0] bus_data;

    for (genvar gi = 0; gi < bits; gi++) begin : g_bus
        bus_rr_arbiter #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_arb (
            .clk    (clk),
            .reset  (reset),
            .pndng  (pndng[gi]),
            .d_pop  (D_pop[gi]),
            .pop    (pop[gi]),
            .push   (push[gi]),
            .d_push (bus_data[gi])
        );

        for (genvar gk = 0; gk < drvrs; gk++) begin : g_dev
            assign D_push[gi][gk] = bus_data[gi];
        end
    end

endmodule

// File: tb/tb_bus_gen_arbiter.sv
module tb_bus_gen_arbiter;

    localparam int BITS  = 1;
    localparam int DRVRS = 4;
    localparam int PW    = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic [BITS-1:0][DRVRS-1:0]         pndng = '0;
    logic [BITS-1:0][DRVRS-1:0][PW-1:0] D_pop = '0;
    logic [BITS-1:0][DRVRS-1:0]         pop;
    logic [BITS-1:0][DRVRS-1:0]         push;
    logic [BITS-1:0][DRVRS-1:0][PW-1:0] D_push;

    bus_gen_arbiter #(
        .bits(BITS), .drvrs(DRVRS), .pckg_sz(PW), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  pop;
        logic [3:0]  push;
        logic [15:0] dpush;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          ptr_m = 0;
    logic [15:0] last_dpush = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: round-robin choice and destination decode, computed
    // from the stimulus currently driven.
    task automatic expect_pkt();
        exp_t        e;
        int          src;
        logic [7:0]  dest;
        logic [3:0]  mask;
        logic [15:0] pkt;
        src = -1;
        for (int off = 0; off < DRVRS; off++) begin
            if (src < 0 && pndng[0][(ptr_m + off) % DRVRS]) src = (ptr_m + off) % DRVRS;
        end
        if (src < 0) src = 0;
        ptr_m = (src + 1) % DRVRS;
        pkt   = D_pop[0][src];
        dest  = pkt[15:8];
        if (dest < 8'(DRVRS)) mask = 4'(1 << dest);
        else if (dest == 8'hFF) begin
`ifdef BCAST_INCL_SRC_EN
            mask = 4'hF;
`else
            mask = 4'hF & ~4'(1 << src);
`endif
        end else mask = 4'h0;
        if (mask != 4'h0) last_dpush = pkt;
        e.pop   = 4'(1 << src);
        e.push  = mask;
        e.dpush = last_dpush;
        sb.push_back(e);
    endtask

    task automatic wait_pop(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pop[0] == 4'h0 && n < 20);
        check("pop_seen", {31'd0, pop[0] != 4'h0}, 32'd1);
    endtask

    task automatic xfer(input string tag, input int exp_wait, input bit drop_pndng);
        exp_t e;
        int   n;
        wait_pop(n);
        check({tag, "_cadence"}, n, exp_wait);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_pop"}, pop[0], e.pop);
        check({tag, "_push_during_pop"}, push[0], 4'h0);
        if (drop_pndng) pndng = '0;
        @(negedge clk);
        check({tag, "_pop_one_cycle"}, pop[0], 4'h0);
        check({tag, "_push"}, push[0], e.push);
        check({tag, "_dpush"}, D_push[0][0], e.dpush);
        check({tag, "_dpush_k3"}, D_push[0][3], e.dpush);
        $display("[TB] %s pop=%b push=%b D_push=%h", tag, e.pop, push[0], D_push[0][0]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   n;

        // 1. reset held with every source pending
        reset = 1'b0;
        pndng = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_pop", pop[0], 4'h0);
            check("rst_push", push[0], 4'h0);
            check("rst_dpush", D_push[0][0], 16'h0);
        end
        $display("[TB] reset held 3 cycles");
        pndng = '0;
        reset = 1'b1;

        // 2. unicast 1 -> 2, pending drops during POP
        pndng[0][1] = 1'b1;
        D_pop[0][1] = 16'h02AB;
        expect_pkt();
        xfer("uni_1to2", 1, 1'b1);

        // 3. broadcast from device 0
        pndng[0][0] = 1'b1;
        D_pop[0][0] = 16'hFF55;
        expect_pkt();
        xfer("bcast_0", 2, 1'b1);

        // 4. all pending, every packet addressed to device 0
        pndng = '1;
        for (int i = 0; i < DRVRS; i++) D_pop[0][i] = 16'(i);
        for (int t = 0; t < 6; t++) begin
            expect_pkt();
            xfer("rr_all", 2, 1'b0);
        end
        pndng = '0;

        // 5. unknown destination is dropped
        pndng[0][2] = 1'b1;
        D_pop[0][2] = 16'h0711;
        expect_pkt();
        xfer("drop_2", 2, 1'b1);

        // 6. reset during POP of device 3
        pndng[0][3] = 1'b1;
        D_pop[0][3] = 16'h0012;
        expect_pkt();
        wait_pop(n);
        check("abort_cadence", n, 2);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("abort_pop", pop[0], e.pop);
        end
        reset = 1'b0;
        @(negedge clk);
        check("abort_pop_clr", pop[0], 4'h0);
        check("abort_push", push[0], 4'h0);
        check("abort_dpush", D_push[0][0], 16'h0);
        @(negedge clk);
        check("abort_push_late", push[0], 4'h0);
        $display("[TB] reset during POP of device 3");
        ptr_m      = 0;
        last_dpush = '0;
        pndng      = '1;
        D_pop[0][0] = 16'h01C0;
        reset = 1'b1;
        expect_pkt();
        xfer("post_rst", 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
